// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared-memory command port.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins contested arbitrations until fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              pick_if, pick_dm;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    starve_cnt_d = starve_cnt_q;
    pick_if      = 1'b0;
    pick_dm      = 1'b0;

    case (state_q)
      IDLE: begin
        pick_if = bus.if_req && (!bus.dm_req || (starve_cnt_q >= LIMIT));
        pick_dm = bus.dm_req && !pick_if;
        if (pick_if) begin
          state_d      = BUSY_I;
          addr_d       = bus.if_addr;
          we_d         = 4'b0000;
          wdata_d      = '0;
          starve_cnt_d = 4'd0;
        end else if (pick_dm) begin
          state_d = BUSY_D;
          addr_d  = bus.dm_addr;
          we_d    = bus.dm_we;
          wdata_d = bus.dm_wdata;
          // Only a data grant that actually made fetch wait counts toward starvation.
          if (bus.if_req) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          if_rdata_d = bus.mem_rdata;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          dm_rdata_d = bus.mem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 4'b0000;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Ack and read data bypass the register so requesters see data in the ack cycle.
  assign bus.if_ack    = (state_q == BUSY_I) && bus.mem_ready;
  assign bus.dm_ack    = (state_q == BUSY_D) && bus.mem_ready;
  assign bus.if_rdata  = bus.if_ack ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = bus.dm_ack ? bus.mem_rdata : dm_rdata_q;
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;

endmodule
